// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// reset address default, NOP word and PC increment.
// Optional feature macro: MISALIGN_TRAP_EN (adds the TRAP state).
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
`ifdef MISALIGN_TRAP_EN
        ,
        ST_TRAP = 2'd3
`endif
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // True when an address is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencing FSM: BOOT -> REQ -> HOLD -> REQ ... with an optional
// terminal TRAP state (MISALIGN_TRAP_EN) entered on a misaligned advance.
module fetch_fsm
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         imem_ack_i,
    input  logic         stall_i,
`ifdef MISALIGN_TRAP_EN
    input  logic         misalign_i,
`endif
    output fetch_state_e state_o,
    output logic         take_o,
    output logic         advance_o
);

    fetch_state_e state_q, state_d;

    // State register, asynchronously forced to BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the accept/advance strobes for the datapath.
    always_comb begin
        state_d   = state_q;
        take_o    = 1'b0;
        advance_o = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (imem_ack_i) begin
                    take_o  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    advance_o = 1'b1;
`ifdef MISALIGN_TRAP_EN
                    state_d = misalign_i ? ST_TRAP : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns pc, latched instruction, valid flag and the
// pc+4 adder; sequencing comes from fetch_fsm.
// Optional feature macro: MISALIGN_TRAP_EN (sticky misalign_trap output).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] jump_Result,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] next_PC,
    output logic [31:0]       instruction,
    output logic              instr_valid
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    fetch_state_e      state;
    logic              take;
    logic              advance;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
`ifdef MISALIGN_TRAP_EN
    logic              trap_q, trap_d;
    logic              misalign;

    assign misalign = is_misaligned(jump_Result);
`endif

    fetch_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_ack_i (imem_ack),
        .stall_i    (stall),
`ifdef MISALIGN_TRAP_EN
        .misalign_i (misalign),
`endif
        .state_o    (state),
        .take_o     (take),
        .advance_o  (advance)
    );

    // Datapath next values: latch the word on accept, redirect pc on advance.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
`ifdef MISALIGN_TRAP_EN
        trap_d  = trap_q;
`endif
        if (take) begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
        end
        if (advance) begin
            valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
            pc_d = jump_Result;
            if (misalign) begin
                trap_d = 1'b1;
            end
`else
            pc_d = jump_Result & ~ADDR_W'(3);
`endif
        end
    end

    // Datapath registers with asynchronous reset to the boot values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
`ifdef MISALIGN_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign next_PC     = pc_q + ADDR_W'(PC_INC);
    assign instruction = instr_q;
    assign instr_valid = valid_q;
`ifdef MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] jump_Result;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] next_PC;
    logic [31:0] instruction;
    logic        instr_valid;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: booting / request outstanding / trapped flags and the
    // architecturally visible values.
    bit          m_boot;
    bit          m_fetch;
    bit          m_trap;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .ADDR_W   (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .jump_Result (jump_Result),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .next_PC     (next_PC),
        .instruction (instruction),
        .instr_valid (instr_valid)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_trap (misalign_trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address, never zero at 0.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".imem_req"},    {31'b0, imem_req},    {31'b0, m_fetch});
        check({ctx, ".imem_addr"},   imem_addr,            m_pc);
        check({ctx, ".pc"},          pc,                   m_pc);
        check({ctx, ".next_PC"},     next_PC,              m_pc + 32'd4);
        check({ctx, ".instruction"}, instruction,          m_instr);
        check({ctx, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
`ifdef MISALIGN_TRAP_EN
        check({ctx, ".misalign_trap"}, {31'b0, misalign_trap}, {31'b0, m_trap});
`endif
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_fetch = 1'b0;
        m_trap  = 1'b0;
        m_pc    = RST_PC;
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock: check outputs at the falling edge, apply inputs, let the
    // rising edge happen, apply the fetch rules to the model, return at the
    // next falling edge.
    task automatic step(input string ctx, input bit ack, input bit stl, input logic [31:0] jmp);
        check_all(ctx);
        imem_ack    = ack;
        stall       = stl;
        jump_Result = jmp;
        @(posedge clk);
        if (m_boot) begin
            m_boot  = 1'b0;
            m_fetch = 1'b1;
        end else if (m_trap) begin
            // only reset leaves the trap
        end else if (m_fetch) begin
            if (ack) begin
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_fetch = 1'b0;
            end
        end else if (!stl) begin
            m_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
            m_pc = jmp;
            if (jmp % 4 != 0) m_trap = 1'b1;
            else              m_fetch = 1'b1;
`else
            m_pc    = jmp - (jmp % 4);
            m_fetch = 1'b1;
`endif
        end
        @(negedge clk);
    endtask

    // Run with ack=1 until a fetched instruction is being held.
    task automatic to_hold(input string ctx);
        for (int i = 0; i < 8; i++) begin
            if (!m_boot && !m_fetch && m_valid) break;
            step(ctx, 1'b1, 1'b0, 32'h0);
        end
        check({ctx, ".reached_hold"}, {31'b0, m_valid}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        stall       = 1'b0;
        jump_Result = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset state, then release: BOOT shows no request.
        check_all("reset");
        rst_n = 1'b1;

        // Ack tied high, jump looped from pc+4: addresses 0, 4, 8.
        for (int i = 0; i < 7; i++) begin
            step("seq", 1'b1, 1'b0, m_pc + 32'd4);
        end
        check("seq.pc_after", m_pc, 32'h0000_000C);

        // Delayed ack at 0x40, with stall asserted in REQ (ignored).
        to_hold("pre40");
        step("adv40", 1'b1, 1'b0, 32'h0000_0040);
        for (int i = 0; i < 3; i++) begin
            step("wait40", 1'b0, 1'b1, 32'hDEAD_BEEF);
        end
        step("ack40", 1'b1, 1'b1, 32'hDEAD_BEEF);
        check("lat40.instr", m_instr, mem_word(32'h40));

        // Five stalled cycles in HOLD with stray ack and jump values.
        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b1, 1'b1, $urandom);
        end

        // Redirect to 0x1000.
        step("adv1000", 1'b0, 1'b0, 32'h0000_1000);
        check("adv1000.pc", m_pc, 32'h0000_1000);
        step("req1000", 1'b1, 1'b0, 32'h0);

        // Wrap of the pc+4 adder at the top of the address space.
        to_hold("prewrap");
        step("advwrap", 1'b0, 1'b0, 32'hFFFF_FFFC);
        step("wrap", 1'b1, 1'b0, 32'h0);
        step("wrap_hold", 1'b0, 1'b1, 32'h0);

        // Reset asserted in the middle of an outstanding request.
        step("advrst", 1'b0, 1'b0, 32'h0000_0200);
        step("reqrst", 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("stray", 1'b1, 1'b0, 32'h0000_0300);
        end

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] j;
            j = $urandom;
`ifdef MISALIGN_TRAP_EN
            j = j & 32'hFFFF_FFFC;
`endif
            step("rand", ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 4), j);
        end

        // Misaligned redirect target.
        to_hold("premis");
        step("advmis", 1'b1, 1'b0, 32'h0000_0102);
        for (int i = 0; i < 4; i++) begin
            step("postmis", 1'b1, 1'b0, 32'h0000_0010);
        end
`ifdef MISALIGN_TRAP_EN
        check("mis.trap", {31'b0, m_trap}, 32'd1);
`else
        check("mis.pc_seen", {31'b0, m_trap}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 Parameter ADDR_W, default 32, PC/address width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 jump_Result  input  32  next-PC selection from the jump stage; sampled only on advance.
REQ-006 stall  input  1  downstream hold; instruction and PC frozen while high.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  read address; always equals pc.
REQ-009 imem_ack  input  1  memory read done; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 pc  output  32  address of the current instruction.
REQ-012 next_PC  output  32  pc + 4, feeding the jump stage.
REQ-013 instruction  output  32  latched instruction word, feeding the jump stage and decode.
REQ-014 instr_valid  output  1  instruction and next_PC are valid for the current pc.
REQ-015 misalign_trap  output  1  sticky trap flag; present only with MISALIGN_TRAP_EN.

Function
REQ-016 FSM states: BOOT, REQ, HOLD, plus TRAP when MISALIGN_TRAP_EN is defined.
REQ-017 BOOT: lasts one cycle after reset release, with imem_req=0; next state is REQ.
REQ-018 REQ: imem_req=1, imem_addr=pc; stays in REQ while imem_ack=0.
REQ-019 REQ with imem_ack=1: instruction<=imem_rdata, instr_valid<=1, imem_req drops next cycle, next state is HOLD.
REQ-020 HOLD with stall=1: instruction, pc and instr_valid hold; imem_req=0.
REQ-021 HOLD with stall=0 (advance): pc<=jump_Result, instr_valid<=0, next state is REQ.
REQ-022 Fetch latency is 1 cycle per instruction plus memory wait cycles; the minimum issue rate is one instruction per 2 cycles.
REQ-023 next_PC = pc + 4 combinationally, modulo 2^32; pc=32'hFFFF_FFFC gives next_PC=32'h0000_0000 with no flag.
REQ-024 imem_ack outside REQ is ignored; it must not change the instruction or the state.
REQ-025 stall in REQ is ignored; stall applies only in HOLD.
REQ-026 jump_Result is ignored in every state except an advance from HOLD.

Reset
REQ-027 On rst_n=0, asynchronously: state=BOOT, pc=RESET_PC, instruction=32'h0000_0000 (NOP), instr_valid=0, imem_req=0, misalign_trap=0.
REQ-028 Reset during REQ abandons the outstanding request; a late imem_ack after reset release is ignored under REQ-024.
REQ-029 All outputs are defined at reset; there are no X values on any output.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN.
REQ-031 With MISALIGN_TRAP_EN: on an advance with jump_Result[1:0]!=0, pc<=jump_Result, state<=TRAP, misalign_trap<=1.
REQ-032 In TRAP: imem_req=0 and instr_valid=0; only reset exits TRAP.
REQ-033 Without MISALIGN_TRAP_EN: pc<={jump_Result[31:2],2'b00}, there is no TRAP state, and the misalign_trap port is absent.

Structure
REQ-034 Shared package fetch_pkg holds the state enum, the RESET_PC default, the NOP constant 32'h0 and the PC_INC=4 constant.
REQ-035 Sub-module fetch_fsm holds the state register and the next-state logic; fetch_unit holds the pc and instruction registers and the adder.

Verification
REQ-036 Reset release with imem_ack tied to 1 -> imem_addr=0, 4, 8 on successive REQ cycles, with jump_Result looped from next_PC.
REQ-037 imem_ack delayed 3 cycles at pc=0x40 -> imem_req held 3 cycles, instruction latched on the ack cycle, instr_valid=1 the next cycle.
REQ-038 stall=1 for 5 cycles in HOLD -> pc, instruction and instr_valid unchanged, imem_req=0 throughout.
REQ-039 Advance with jump_Result=0x0000_1000 -> the next imem_addr is 0x1000 and next_PC is 0x1004.
REQ-040 rst_n pulsed low mid-REQ, then a stray imem_ack -> pc=RESET_PC, instr_valid=0, stray ack ignored.
REQ-041 jump_Result=0x102 on advance -> with the macro: misalign_trap=1 and no further requests; without the macro: imem_addr=0x100.
